fp_ieee_to_flopoco: RTL



---
 rtl/fp_ieee_to_flopoco.sv | 69 ++++++
 1 files changed

// File: rtl/fp_ieee_to_flopoco.sv
// fp_ieee_to_flopoco: two-stage valid/ready converter from IEEE-style minifloat to FloPoCo format,
// flushing subnormals to zero and counting flushed words delivered.
module fp_ieee_to_flopoco #(
  parameter int WE = 4,
  parameter int WF = 3,
  parameter int ID = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WE+WF:0]    in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WE+WF+2:0]  out_data,
  output logic              out_flush,
  output logic [15:0]       flush_cnt
);
  // The instance tag only names the instance; it folds into a zero constant.
  localparam logic [15:0] CNT_RST = 16'(ID) & 16'h0000;
  logic              s1_valid_q, s1_flush_q, flush_d, out_valid_q, out_flush_q, s1_adv, s2_adv;
  logic [WE+WF:0]    s1_word_q;
  logic [1:0]        s1_exc_q, exc_d;
  logic [WE+WF+2:0]  out_data_q, out_data_d;
  logic [15:0]       flush_cnt_q;
  logic [WE-1:0]     e;
  logic [WF-1:0]     f;
  assign e = in_data[WE+WF-1:WF];
  assign f = in_data[WF-1:0];
  always_comb begin
    s2_adv     = !out_valid_q | out_ready;
    s1_adv     = !s1_valid_q | s2_adv;
    in_ready   = s1_adv & !rst;
    exc_d      = e == '0 ? 2'b00 : e == '1 ? {1'b1, f != '0} : 2'b01;
    flush_d    = e == '0 && f != '0;
    out_data_d = {s1_exc_q, s1_word_q[WE+WF],
                  s1_exc_q == 2'b01 ? s1_word_q[WE+WF-1:0] : {(WE+WF){1'b0}}};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_word_q   <= '0;
      s1_exc_q    <= 2'b00;
      s1_flush_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_flush_q <= 1'b0;
      flush_cnt_q <= CNT_RST;
    end else begin
      if (s1_adv) s1_valid_q <= in_valid;
      if (s1_adv && in_valid) begin
        s1_word_q  <= in_data;
        s1_exc_q   <= exc_d;
        s1_flush_q <= flush_d;
      end
      if (s2_adv) out_valid_q <= s1_valid_q;
      if (s2_adv && s1_valid_q) begin
        out_data_q  <= out_data_d;
        out_flush_q <= s1_flush_q;
      end
      if (out_valid_q && out_ready && out_flush_q && flush_cnt_q != 16'hFFFF)
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_flush = out_flush_q;
  assign flush_cnt = flush_cnt_q;
endmodule
